// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   arb_state_e : arbitration FSM states (RR, LOCKED, FORCE)
//   PORT_CPU    : port id of the CPU data port (port 0)
//   PORT_LOAD   : port id of the program loader / debug port (port 1)
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RR     = 2'd0,
        LOCKED = 2'd1,
        FORCE  = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/mem_arbiter_rd_return_pipe.sv
// ---------------------------------------------------------------------------
// rd_return_pipe
// One-stage read-return pipeline. Records (valid, port id) of a read grant
// and, one cycle later, raises the matching rvalid and routes mem_rdata to
// that port. Data outputs are forced to 0 whenever their rvalid is low.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   rd_fire_i       : a read was granted this cycle
//   rd_id_i         : port id of that read grant
//   mem_rdata_i     : synchronous-read data from memory
//   rvalid0_o/1_o   : read data valid per port
//   rdata0_o/1_o    : read data per port
// ---------------------------------------------------------------------------
module rd_return_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_fire_i,
    input  logic              rd_id_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o
);

    logic valid_q;
    logic id_q;

    // Reset clears valid so an in-flight read is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= PORT_CPU;
        end else begin
            valid_q <= rd_fire_i;
            id_q    <= rd_id_i;
        end
    end

    always_comb begin
        rvalid0_o = valid_q && (id_q == PORT_CPU);
        rvalid1_o = valid_q && (id_q == PORT_LOAD);
        rdata0_o  = rvalid0_o ? mem_rdata_i : '0;
        rdata1_o  = rvalid1_o ? mem_rdata_i : '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single synchronous-read memory.
// Port 0 is the CPU data port, port 1 the program loader / debug port.
// Round-robin on conflicts; port 1 may lock the memory with lock1, bounded
// by LOCK_MAX consecutive grants after which port 0 is served once.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   req0/1, we0/1              : request, write enable per port
//   addr0/1, wdata0/1          : address, write data per port
//   lock1                      : port 1 requests exclusive ownership
//   gnt0/1                     : combinational grant per port
//   rvalid0/1, rdata0/1        : read return per port (one cycle after grant)
//   stall0                     : req0 high without gnt0
//   mem_en/we/addr/wdata       : memory command
//   mem_rdata                  : memory read data (one cycle after read)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              stall0,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned          CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic gnt0_raw, gnt1_raw;
    logic at_max;
    logic rd_fire, rd_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RR;
            last_gnt_q <= PORT_LOAD;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next state and raw grants. A LOCKED cycle with lock1 low is arbitrated
    // exactly like RR, so both share the final branch.
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        at_max   = (cnt_q >= CNT_MAX);

        if (state_q == FORCE) begin
            // Port 1 blocked; serve port 0 once, or give up if it left.
            cnt_d = '0;
            if (req0) begin
                gnt0_raw = 1'b1;
                state_d  = lock1 ? LOCKED : RR;
            end else begin
                state_d = RR;
            end
        end else if (state_q == LOCKED && lock1) begin
            // Once at the limit with port 0 waiting, port 1 is held off.
            if (req1 && !(at_max && req0)) begin
                gnt1_raw = 1'b1;
                if (!at_max) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            state_d = (req0 && (cnt_d >= CNT_MAX)) ? FORCE : LOCKED;
        end else begin
            if (req0 && req1) begin
                if (last_gnt_q == PORT_LOAD) begin
                    gnt0_raw = 1'b1;
                end else begin
                    gnt1_raw = 1'b1;
                end
            end else begin
                gnt0_raw = req0;
                gnt1_raw = req1;
            end
            if (gnt1_raw && lock1) begin
                state_d = LOCKED;
                cnt_d   = CNT_ONE;
            end else begin
                state_d = RR;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0_raw) begin
            last_gnt_d = PORT_CPU;
        end else if (gnt1_raw) begin
            last_gnt_d = PORT_LOAD;
        end
    end

    // Outputs are held quiet for the whole reset interval.
    always_comb begin
        gnt0   = gnt0_raw && !rst;
        gnt1   = gnt1_raw && !rst;
        stall0 = req0 && !gnt0;
        mem_en = gnt0 || gnt1;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
        rd_fire = (gnt0 && !we0) || (gnt1 && !we1);
        rd_id   = gnt1 ? PORT_LOAD : PORT_CPU;
    end

    rd_return_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_return_pipe (
        .clk         (clk),
        .rst         (rst),
        .rd_fire_i   (rd_fire),
        .rd_id_i     (rd_id),
        .mem_rdata_i (mem_rdata),
        .rvalid0_o   (rvalid0),
        .rvalid1_o   (rvalid1),
        .rdata0_o    (rdata0),
        .rdata1_o    (rdata1)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, stall0, mem_en, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63];

    mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .LOCK_MAX (LM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .stall0    (stall0),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter: word array, synchronous read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: who owns the memory, how many lock grants so far,
    // whether port 0 is owed a forced slot, and who was served last.
    bit          m_lock_on, m_force, m_last;
    int          m_lock_cnt;
    bit          m_pv0, m_pv1;
    logic [31:0] m_pd;
    bit          e0, e1, ewe;
    logic [31:0] ea, ewd;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_gnt0", 32'(gnt0), 32'd0);
            check("rst_gnt1", 32'(gnt1), 32'd0);
            check("rst_mem_en", 32'(mem_en), 32'd0);
            check("rst_rvalid0", 32'(rvalid0), 32'd0);
            check("rst_rvalid1", 32'(rvalid1), 32'd0);
            check("rst_rdata0", rdata0, 32'd0);
            check("rst_rdata1", rdata1, 32'd0);
            m_lock_on = 0; m_force = 0; m_last = 1; m_lock_cnt = 0;
            m_pv0 = 0; m_pv1 = 0; m_pd = '0;
        end else begin
            e0 = 0; e1 = 0;
            if (m_force) begin
                e0 = req0;
            end else if (m_lock_on && lock1) begin
                e1 = req1 && !(m_lock_cnt >= LM && req0);
            end else if (req0 && req1) begin
                if (m_last) e0 = 1; else e1 = 1;
            end else begin
                e0 = req0; e1 = req1;
            end
            ewe = e0 ? we0 : (e1 ? we1 : 1'b0);
            ea  = e0 ? addr0 : (e1 ? addr1 : 32'd0);
            ewd = e0 ? wdata0 : (e1 ? wdata1 : 32'd0);

            check("gnt0", 32'(gnt0), 32'(e0));
            check("gnt1", 32'(gnt1), 32'(e1));
            check("stall0", 32'(stall0), 32'(req0 && !e0));
            check("mem_en", 32'(mem_en), 32'(e0 || e1));
            check("mem_we", 32'(mem_we), 32'(ewe));
            check("mem_addr", mem_addr, ea);
            check("mem_wdata", mem_wdata, ewd);
            check("rvalid0", 32'(rvalid0), 32'(m_pv0));
            check("rvalid1", 32'(rvalid1), 32'(m_pv1));
            check("rdata0", rdata0, m_pv0 ? m_pd : 32'd0);
            check("rdata1", rdata1, m_pv1 ? m_pd : 32'd0);

            m_pv0 = e0 && !ewe;
            m_pv1 = e1 && !ewe;
            m_pd  = mem[ea[7:2]];
            if (e0 || e1) m_last = e1;
            if (m_force) begin
                m_force    = 0;
                m_lock_on  = e0 && lock1;
                m_lock_cnt = 0;
            end else if (m_lock_on && lock1) begin
                if (e1 && m_lock_cnt < LM) m_lock_cnt++;
                if (m_lock_cnt >= LM && req0) m_force = 1;
            end else begin
                m_lock_on  = e1 && lock1;
                m_lock_cnt = m_lock_on ? 1 : 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
    endtask

    logic [5:0] exp_g1, exp_st;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);

        // Reset state.
        step(); step();
        @(negedge clk);
        check("hand_rst_gnt0", 32'(gnt0), 32'd0);
        check("hand_rst_rvalid0", 32'(rvalid0), 32'd0);
        step(); rst = 0;

        // Idle for 10 cycles.
        repeat (10) step();
        @(negedge clk);
        check("hand_idle_mem_en", 32'(mem_en), 32'd0);

        // Single read from port 0.
        step(); req0 = 1; addr0 = 32'h10;
        @(negedge clk);
        check("hand_rd_gnt0", 32'(gnt0), 32'd1);
        check("hand_rd_addr", mem_addr, 32'h10);
        step(); req0 = 0;
        @(negedge clk);
        check("hand_rd_rvalid0", 32'(rvalid0), 32'd1);
        check("hand_rd_rdata0", rdata0, 32'hA500_0004);

        // Conflict after reset: 0,1,0,1.
        step(); rst = 1;
        step(); rst = 0;
        req0 = 1; req1 = 1; addr0 = 32'h20; addr1 = 32'h24;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hand_cf_gnt0", 32'(gnt0), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("hand_cf_gnt1", 32'(gnt1), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) check("hand_cf_rvalid0", 32'(rvalid0), (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        idle();
        @(negedge clk);
        check("hand_cf_rvalid1", 32'(rvalid1), 32'd1);
        check("hand_cf_rdata1", rdata1, 32'hA500_0009);

        // Lock with LOCK_MAX=4: four gnt1, one forced gnt0, then gnt1 again.
        step(); req1 = 1; lock1 = 1; addr1 = 32'h30;
        exp_g1 = 6'b101111;
        exp_st = 6'b101110;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("hand_lk_gnt1", 32'(gnt1), 32'(exp_g1[j]));
            check("hand_lk_stall0", 32'(stall0), 32'(exp_st[j]));
            step();
            if (j == 0) begin req0 = 1; addr0 = 32'h34; end
        end
        @(negedge clk);
        check("hand_lk_gnt1_again", 32'(gnt1), 32'd1);
        // Unlock with port 0 waiting: port 0 wins in the same cycle.
        step(); lock1 = 0;
        @(negedge clk);
        check("hand_unlock_gnt0", 32'(gnt0), 32'd1);
        check("hand_unlock_gnt1", 32'(gnt1), 32'd0);
        step(); idle();

        // Port 1 write, then port 0 read-back.
        step(); req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'hDEAD_BEEF;
        @(negedge clk);
        check("hand_wr_gnt1", 32'(gnt1), 32'd1);
        check("hand_wr_mem_we", 32'(mem_we), 32'd1);
        check("hand_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        step(); req1 = 0; we1 = 0; req0 = 1; addr0 = 32'h40;
        @(negedge clk);
        check("hand_wr_no_rvalid1", 32'(rvalid1), 32'd0);
        step(); req0 = 0;
        @(negedge clk);
        check("hand_rb_rvalid0", 32'(rvalid0), 32'd1);
        check("hand_rb_rdata0", rdata0, 32'hDEAD_BEEF);

        // Asynchronous reset mid-lock with a read in flight.
        step(); req1 = 1; lock1 = 1; addr1 = 32'h44;
        @(negedge clk);
        check("hand_rl_gnt1", 32'(gnt1), 32'd1);
        step();
        #2;
        check("hand_rl_rvalid1_pre", 32'(rvalid1), 32'd1);
        rst = 1;
        #1;
        check("hand_rl_rvalid1", 32'(rvalid1), 32'd0);
        check("hand_rl_gnt1_rst", 32'(gnt1), 32'd0);
        check("hand_rl_mem_en", 32'(mem_en), 32'd0);
        check("hand_rl_rdata1", rdata1, 32'd0);
        step(); rst = 0;
        req0 = 1; req1 = 1; lock1 = 0; addr0 = 32'h48; addr1 = 32'h4C;
        @(negedge clk);
        check("hand_post_rst_gnt0", 32'(gnt0), 32'd1);
        step(); idle();

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst    = ($urandom_range(0, 399) == 0);
            req0   = ($urandom_range(0, 2) != 0);
            req1   = ($urandom_range(0, 2) != 0);
            we0    = ($urandom_range(0, 3) == 0);
            we1    = ($urandom_range(0, 3) == 0);
            addr0  = 32'($urandom_range(0, 15)) << 2;
            addr1  = 32'($urandom_range(0, 15)) << 2;
            wdata0 = $urandom;
            wdata1 = $urandom;
            if ($urandom_range(0, 7) == 0) lock1 = ~lock1;
        end
        step(); rst = 0; idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter LOCK_MAX, default 16, maximum consecutive locked grants to port 1 before forced release.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req0/req1  input  1 each  access request; port 0 = CPU data port, port 1 = program loader/debug port.
REQ-007 we0/we1  input  1 each  1 = write, 0 = read.
REQ-008 addr0/addr1  input  ADDR_W each  access address.
REQ-009 wdata0/wdata1  input  DATA_W each  write data.
REQ-010 lock1  input  1  port 1 requests exclusive ownership.
REQ-011 gnt0/gnt1  output  1 each  request accepted this cycle (combinational).
REQ-012 rvalid0/rvalid1  output  1 each  read data valid, exactly one cycle after the read grant.
REQ-013 rdata0/rdata1  output  DATA_W each  read data, valid only while the matching rvalid is high, else 0.
REQ-014 stall0  output  1  high whenever req0 is high and gnt0 is low.
REQ-015 mem_en, mem_we  output  1 each  memory access strobe, write enable.
REQ-016 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address, write data.
REQ-017 mem_rdata  input  DATA_W  synchronous-read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-018 At most one of gnt0/gnt1 SHALL be high in any cycle; a grant is issued only to a requesting port.
REQ-019 On grant, mem_en=1 and mem_we/addr/wdata SHALL be the winner's inputs in the same cycle; with no grant, mem_en=0 and other memory outputs 0.
REQ-020 FSM states: RR, LOCKED, FORCE.
REQ-021 RR: single requester wins; on a conflict, the port not granted most recently (last_gnt register) wins; grants may be back-to-back every cycle.
REQ-022 RR -> LOCKED when port 1 is granted with lock1=1; lock counter loads 1.
REQ-023 LOCKED: only port 1 may be granted; counter increments per port-1 grant; req0 stalls.
REQ-024 LOCKED -> RR when lock1=0 (evaluated in the same cycle, so that cycle arbitrates as RR).
REQ-025 LOCKED -> FORCE when the counter reaches LOCK_MAX and req0=1; if req0=0 at LOCK_MAX, the counter saturates and stays LOCKED.
REQ-026 FORCE: port 1 is blocked; when req0=1, port 0 gets exactly one grant, then -> LOCKED if lock1=1 (counter reloads 0), else RR; if req0 drops first -> RR.
REQ-027 Read return: a one-stage pipeline register (valid, port id) SHALL drive the rvalid of the granted port the cycle after a read grant, with rdata = mem_rdata; a write produces no rvalid.
REQ-028 Back-to-back reads on alternating ports SHALL return in grant order with no bubble.
REQ-029 Simultaneous request, deassertion of a different port, and lock changes in one cycle are resolved purely by the current state and current inputs; inputs are never queued.
REQ-030 last_gnt SHALL update on every grant, including locked and forced grants.

Reset
REQ-031 While rst is high: state=RR, last_gnt=1 (port 0 wins the first conflict), lock counter=0, read pipeline valid=0.
REQ-032 While rst is high: all gnt, rvalid, and mem_en outputs are 0; rdata is 0.
REQ-033 Reset mid-read SHALL drop the pending rvalid.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (RR, LOCKED, FORCE) and the port-id constants (PORT_CPU=0, PORT_LOAD=1).
REQ-035 The read-return pipeline SHALL be a sub-module, rd_return_pipe (valid, id, data routing).
REQ-036 Arbitration logic and FSM SHALL live in mem_arbiter.

Verification
REQ-037 Idle: with no requests, mem_en and both gnts stay 0 for 10 cycles; with only req0 (read, 0x10), gnt0 is high that cycle and rvalid0 plus mem_rdata follow the next cycle.
REQ-038 Conflict: req0 and req1 both held, reads; after reset, grants are 0,1,0,1 on consecutive cycles; each rvalid is on the correct port one cycle later.
REQ-039 Lock: lock1 and req1 held, req0 held, LOCK_MAX=4; sequence is 4×gnt1, 1×gnt0, then gnt1 resumes; stall0 is high exactly on the non-granted req0 cycles.
REQ-040 Unlock: lock1 drops after 2 locked grants with req0 pending; gnt0 occurs in that same cycle.
REQ-041 Write: port 1 write 0xDEADBEEF to 0x40 yields mem_we=1, mem_wdata=0xDEADBEEF, with no rvalid; a subsequent port 0 read of 0x40 returns 0xDEADBEEF.
REQ-042 Reset: rst asserted asynchronously mid-lock with a read in flight gives immediate outputs 0; after release, the first conflict is granted to port 0.
